// File: rtl/satd_pkg.sv
// Shared definitions for the SATD datapath.
//   DIFF_W    : width of one signed residual sample entering the transform
//   HAD_W     : width of one signed Hadamard coefficient leaving the row stage
//   N_PTS     : transform length (lanes per row)
//   ROWS      : rows per 8x8 block
//   row_idx_t : row index within a block
//   row_tag_t : row index plus block-boundary flags, carried with each row
//   pack_had  : places coefficient h_k at bits [k*HAD_W +: HAD_W] of the output bus
package satd_pkg;

  localparam int LENGTH = 11;
  localparam int DIFF_W = LENGTH + 2;
  localparam int HAD_W  = LENGTH + 5;
  localparam int N_PTS  = 8;
  localparam int ROWS   = 8;

  typedef logic [2:0] row_idx_t;

  typedef struct packed {
    logic     last;
    logic     sof;
    row_idx_t row;
  } row_tag_t;

  function automatic logic [N_PTS*HAD_W-1:0] pack_had(input logic [N_PTS-1:0][HAD_W-1:0] h);
    logic [N_PTS*HAD_W-1:0] bus;
    for (int k = 0; k < N_PTS; k++) begin
      bus[k*HAD_W +: HAD_W] = h[k];
    end
    return bus;
  endfunction

endpackage

// File: rtl/hadamard_bfly_stage.sv
// One radix-2 butterfly layer of the 8-point Hadamard transform.
// Lane k pairs with lane k^STRIDE: the lower lane of each pair takes the
// sum, the upper lane takes lower minus upper. Results grow by one bit and
// are sign-extended, so nothing ever wraps.
//   clk       : rising-edge clock
//   clr       : synchronous clear of valid, tag and data
//   en        : advance; when low every register holds
//   in_valid  : incoming lane data is a real row
//   in_tag    : row tag passed through unchanged
//   in_data   : N_PTS signed lanes of IN_W bits
//   out_valid : registered valid
//   out_tag   : registered tag
//   out_data  : N_PTS signed lanes of IN_W+1 bits
module hadamard_bfly_stage
  import satd_pkg::*;
#(
  parameter int IN_W   = DIFF_W,
  parameter int STRIDE = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       in_valid,
  input  row_tag_t                   in_tag,
  input  logic [N_PTS-1:0][IN_W-1:0] in_data,
  output logic                       out_valid,
  output row_tag_t                   out_tag,
  output logic [N_PTS-1:0][IN_W:0]   out_data
);

  localparam int OUT_W = IN_W + 1;

  function automatic logic signed [OUT_W-1:0] bfly_add(input logic signed [IN_W-1:0] x,
                                                       input logic signed [IN_W-1:0] y);
    logic signed [OUT_W-1:0] xs;
    logic signed [OUT_W-1:0] ys;
    xs = {x[IN_W-1], x};
    ys = {y[IN_W-1], y};
    return xs + ys;
  endfunction

  function automatic logic signed [OUT_W-1:0] bfly_sub(input logic signed [IN_W-1:0] x,
                                                       input logic signed [IN_W-1:0] y);
    logic signed [OUT_W-1:0] xs;
    logic signed [OUT_W-1:0] ys;
    xs = {x[IN_W-1], x};
    ys = {y[IN_W-1], y};
    return xs - ys;
  endfunction

  logic [N_PTS-1:0][OUT_W-1:0] bfly_c;

  for (genvar k = 0; k < N_PTS; k++) begin : g_lane
    if ((k & STRIDE) == 0) begin : g_add
      assign bfly_c[k] = bfly_add(in_data[k], in_data[k+STRIDE]);
    end else begin : g_sub
      assign bfly_c[k] = bfly_sub(in_data[k-STRIDE], in_data[k]);
    end
  end

  // ---- register boundary ----
  always_ff @(posedge clk) begin
    if (clr) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_tag   <= in_tag;
      out_data  <= bfly_c;
    end
  end

endmodule

// File: rtl/hadamard_row_stage.sv
// Pipelined 8-point 1-D Hadamard transform of one residual row per cycle.
// Three butterfly layers (strides 4, 2, 1) give coefficients in natural
// Hadamard order: h_k = sum_n d_n * (-1)^popcount(k & n).
// The pipeline stalls as a whole: every stage advances only when the output
// register is empty or being drained.
//   clk, rst           : clock, synchronous active-high reset
//   diff_0 .. diff_7   : signed residual row
//   in_valid, in_sof   : row present / row starts a new 8x8 block
//   in_ready           : row is taken this cycle
//   had_out            : h_k in bits [k*HAD_W +: HAD_W]
//   out_valid, out_ready : output handshake
//   out_row, out_sof, out_last : row tag within the block
//   err_align          : sticky, set when a block start arrives mid-block
module hadamard_row_stage
  import satd_pkg::*;
#(
  parameter int LENGTH = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [LENGTH+1:0]    diff_0,
  input  logic signed [LENGTH+1:0]    diff_1,
  input  logic signed [LENGTH+1:0]    diff_2,
  input  logic signed [LENGTH+1:0]    diff_3,
  input  logic signed [LENGTH+1:0]    diff_4,
  input  logic signed [LENGTH+1:0]    diff_5,
  input  logic signed [LENGTH+1:0]    diff_6,
  input  logic signed [LENGTH+1:0]    diff_7,
  input  logic                        in_valid,
  input  logic                        in_sof,
  output logic                        in_ready,
  output logic [8*(LENGTH+5)-1:0]     had_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2:0]                  out_row,
  output logic                        out_sof,
  output logic                        out_last,
  output logic                        err_align
);

  localparam int DW = LENGTH + 2;

  logic                     en;
  logic                     acc;
  row_idx_t                 row_q;
  row_idx_t                 row_p0;
  row_tag_t                 tag_p0;
  logic [N_PTS-1:0][DW-1:0] d_p0;

  logic                     vld_p1;
  row_tag_t                 tag_p1;
  logic [N_PTS-1:0][DW:0]   a_p1;

  logic                     vld_p2;
  row_tag_t                 tag_p2;
  logic [N_PTS-1:0][DW+1:0] b_p2;

  logic                     vld_p3;
  row_tag_t                 tag_p3;
  logic [N_PTS-1:0][DW+2:0] h_p3;

  // Depends only on the output register state, never on in_valid.
  assign en       = !vld_p3 || out_ready;
  assign in_ready = en;
  assign acc      = in_valid && en;

  // A block start forces the tag to 0; otherwise the counter supplies it.
  assign row_p0 = in_sof ? row_idx_t'(0) : row_q;
  assign tag_p0 = {(row_p0 == row_idx_t'(ROWS - 1)), (row_p0 == row_idx_t'(0)), row_p0};
  assign d_p0   = {diff_7, diff_6, diff_5, diff_4, diff_3, diff_2, diff_1, diff_0};

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q     <= '0;
      err_align <= 1'b0;
    end else if (acc) begin
      row_q <= row_p0 + row_idx_t'(1);
      if (in_sof && (row_q != row_idx_t'(0))) begin
        err_align <= 1'b1;
      end
    end
  end

  // ---- p0 -> p1 : stride-4 butterflies ----
  hadamard_bfly_stage #(
    .IN_W   (DW),
    .STRIDE (4)
  ) u_bfly_p1 (
    .clk       (clk),
    .clr       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_tag    (tag_p0),
    .in_data   (d_p0),
    .out_valid (vld_p1),
    .out_tag   (tag_p1),
    .out_data  (a_p1)
  );

  // ---- p1 -> p2 : stride-2 butterflies ----
  hadamard_bfly_stage #(
    .IN_W   (DW + 1),
    .STRIDE (2)
  ) u_bfly_p2 (
    .clk       (clk),
    .clr       (rst),
    .en        (en),
    .in_valid  (vld_p1),
    .in_tag    (tag_p1),
    .in_data   (a_p1),
    .out_valid (vld_p2),
    .out_tag   (tag_p2),
    .out_data  (b_p2)
  );

  // ---- p2 -> p3 : stride-1 butterflies, output register ----
  hadamard_bfly_stage #(
    .IN_W   (DW + 2),
    .STRIDE (1)
  ) u_bfly_p3 (
    .clk       (clk),
    .clr       (rst),
    .en        (en),
    .in_valid  (vld_p2),
    .in_tag    (tag_p2),
    .in_data   (b_p2),
    .out_valid (vld_p3),
    .out_tag   (tag_p3),
    .out_data  (h_p3)
  );

  assign had_out   = pack_had(h_p3);
  assign out_valid = vld_p3;
  assign out_row   = tag_p3.row;
  assign out_sof   = tag_p3.sof;
  assign out_last  = tag_p3.last;

endmodule

// File: tb/tb_hadamard_row_stage.sv
module tb_hadamard_row_stage;

  localparam int DW = 13;
  localparam int HW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] d [8];
  logic                 in_valid, in_sof, in_ready;
  logic [8*HW-1:0]      had_out;
  logic                 out_valid, out_ready, out_sof, out_last, err_align;
  logic [2:0]           out_row;

  hadamard_row_stage #(.LENGTH(11)) dut (
    .clk(clk), .rst(rst),
    .diff_0(d[0]), .diff_1(d[1]), .diff_2(d[2]), .diff_3(d[3]),
    .diff_4(d[4]), .diff_5(d[5]), .diff_6(d[6]), .diff_7(d[7]),
    .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
    .had_out(had_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_sof(out_sof), .out_last(out_last),
    .err_align(err_align)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*HW-1:0] had;
    logic [2:0]      row;
    logic            sof;
    logic            last;
    int              acc;
    bit              chk_lat;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;
  int   brow   = 0;
  bit   pat_on = 1'b0;
  int   pat_i  = 0;
  bit [3:0] pat = 4'b1001;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Hadamard matrix definition, natural order.
  function automatic logic [8*HW-1:0] model(input int v[8]);
    logic [8*HW-1:0] r;
    int s;
    for (int k = 0; k < 8; k++) begin
      s = 0;
      for (int n = 0; n < 8; n++) begin
        if ($countones(k & n) % 2 == 1) s -= v[n];
        else s += v[n];
      end
      r[k*HW +: HW] = HW'(s);
    end
    return r;
  endfunction

  // Output monitor: scoreboard pops and stall-stability checks.
  exp_t            e;
  bit              hold = 1'b0;
  logic [8*HW-1:0] held_had;
  logic [4:0]      held_tag;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", had_out, held_had);
        check("stall_tags", {out_row, out_sof, out_last}, held_tag);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("had", had_out, e.had);
          check("row", out_row, e.row);
          check("sof", out_sof, e.sof);
          check("last", out_last, e.last);
          if (e.chk_lat) check("latency", cyc - e.acc, 3);
        end
        hold = 1'b0;
      end else if (out_valid) begin
        hold     = 1'b1;
        held_had = had_out;
        held_tag = {out_row, out_sof, out_last};
      end else begin
        hold = 1'b0;
      end
    end
  end

  // Ends 2 time units after a rising edge with out_ready settled.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pat_on) begin
      out_ready = pat[3 - (pat_i % 4)];
      pat_i++;
    end
    #1;
  endtask

  task automatic send(input int v[8], input bit sof, input bit lat);
    int n;
    bit ok;
    exp_t x;
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < 8; k++) d[k] = DW'(v[k]);
    in_sof   = sof;
    in_valid = 1'b1;
    while (!ok && n < 50) begin
      if (in_ready) begin
        x.row     = sof ? 3'd0 : 3'(brow);
        brow      = (int'(x.row) + 1) % 8;
        x.sof     = (x.row == 3'd0);
        x.last    = (x.row == 3'd7);
        x.had     = model(v);
        x.acc     = cyc;
        x.chk_lat = lat;
        sb.push_back(x);
        ok = 1'b1;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (!ok) check("accept_timeout", in_ready, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  function automatic void rnd_row(output int v[8]);
    for (int k = 0; k < 8; k++) v[k] = int'($urandom_range(0, 8191)) - 4096;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[8];
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) d[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_had", had_out, 0);
    check("rst_tags", {out_row, out_sof, out_last}, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_err", err_align, 0);
    rst = 1'b0;
    #1;

    // Directed data patterns, one block: rows 0..7.
    for (int k = 0; k < 8; k++) v[k] = 1;
    send(v, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) v[k] = k;
    send(v, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) v[k] = -4096;
    send(v, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) v[k] = (k % 2 == 0) ? 4095 : -4095;
    send(v, 1'b0, 1'b1);
    for (int r = 4; r < 8; r++) begin
      rnd_row(v);
      send(v, 1'b0, 1'b1);
    end
    drain();
    check("err_clean_block", err_align, 0);

    // 16 back-to-back rows with out_ready pattern 1,0,0,1.
    pat_i  = 0;
    pat_on = 1'b1;
    for (int r = 0; r < 16; r++) begin
      rnd_row(v);
      send(v, (r % 8 == 0), 1'b0);
    end
    drain();
    pat_on    = 1'b0;
    out_ready = 1'b1;
    tick();
    check("no_dup_after_drain", out_valid, 0);
    check("err_two_blocks", err_align, 0);

    // Misaligned block start on row 3.
    for (int r = 0; r < 3; r++) begin
      rnd_row(v);
      send(v, (r == 0), 1'b1);
    end
    check("err_before_bad_sof", err_align, 0);
    rnd_row(v);
    send(v, 1'b1, 1'b1);
    for (int r = 0; r < 2; r++) begin
      rnd_row(v);
      send(v, 1'b0, 1'b1);
    end
    drain();
    check("err_set", err_align, 1);
    repeat (3) tick();
    check("err_sticky", err_align, 1);

    // Reset with three rows in flight and the output stalled.
    out_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      rnd_row(v);
      send(v, 1'b0, 1'b0);
    end
    check("stalled_before_rst", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    brow = 0;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_had", had_out, 0);
    check("rst2_tags", {out_row, out_sof, out_last}, 0);
    check("rst2_in_ready", in_ready, 1);
    check("rst2_err", err_align, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) v[k] = 100 * k - 350;
    send(v, 1'b0, 1'b1);
    drain();
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
